uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter between `N_REQ` byte sources in the board design. It latches the winning requester's byte and drives the transmitter's start/data inputs. It holds start until the transmitter reports busy, then waits for the frame to finish before serving the next requester. The block runs entirely on the system clock; the transmitter's baud-rate domain is seen only through `i_tx_busy`.

---
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources.
// Optional LAUNCH watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_ack,
  output logic [N_REQ-1:0]        o_done,
  output logic                    o_tx_start,
  output logic [DATA_W-1:0]       o_tx_data,
  input  logic                    i_tx_busy,
  output logic [2:0]              o_grant_id,
  output logic                    o_busy,
  output logic                    o_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        ptr;
  logic [2:0]        win_id;
  logic              win_vld;
  logic              grant;
  logic              tmo_hit;
  logic [N_REQ-1:0]  ack_q;

  // Walk downward so the closest set bit after ptr is the last one written.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (i_req[(int'(ptr) + i) % N_REQ]) begin
        win_vld = 1'b1;
        win_id  = 3'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  assign grant = (state == IDLE) && !i_tx_busy && win_vld;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (grant) state_nxt = LAUNCH;
      LAUNCH: if (i_tx_busy) state_nxt = SEND;
              else if (tmo_hit) state_nxt = DONE;
      SEND:   if (!i_tx_busy) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      ptr        <= 3'(N_REQ - 1);
      o_grant_id <= '0;
      o_tx_data  <= '0;
      ack_q      <= '0;
    end else begin
      state <= state_nxt;
      ack_q <= '0;
      if (grant) begin
        o_grant_id <= win_id;
        o_tx_data  <= i_data[win_id*DATA_W +: DATA_W];
        ack_q      <= N_REQ'(1) << win_id;
      end
      if (state == DONE) ptr <= o_grant_id;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        err_q;

  assign tmo_hit = (state == LAUNCH) && !i_tx_busy && (tmo_cnt == 16'(TIMEOUT - 1));

  // Counts LAUNCH cycles without busy; any exit from LAUNCH clears it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (state == LAUNCH && !i_tx_busy && !tmo_hit) tmo_cnt <= tmo_cnt + 16'd1;
      else                                           tmo_cnt <= '0;
    end
  end

  assign o_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_hit        = 1'b0;
  assign o_err          = 1'b0;
`endif

  assign o_ack      = ack_q;
  assign o_done     = (state == DONE) ? (N_REQ'(1) << o_grant_id) : '0;
  assign o_tx_start = (state == LAUNCH);
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, latency, busy handling, reset abort, watchdog.
module tb_uart_tx_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_ack;
  logic [3:0]  o_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;
  logic [2:0]  o_grant_id;
  logic        o_busy;
  logic        o_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] byte_of [4] = '{8'hA5, 8'h5A, 8'h96, 8'h3C};
  int         rr_exp  [6] = '{0, 1, 2, 3, 0, 1};

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT(20)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
    .o_ack(o_ack), .o_done(o_done), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_busy(i_tx_busy), .o_grant_id(o_grant_id), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
  endtask

  // Entered in the first LAUNCH cycle; leaves in the IDLE cycle after DONE.
  task automatic run_frame(input int start_cycles, input int busy_cycles,
                           input logic [3:0] exp_done, input logic [7:0] exp_data);
    for (int i = 1; i < start_cycles; i++) begin
      chk("start_hold", o_tx_start, 1'b1);
      tick();
    end
    chk("start_last", o_tx_start, 1'b1);
    i_tx_busy = 1'b1;
    tick();
    chk("start_drop", o_tx_start, 1'b0);
    chk("busy_send", o_busy, 1'b1);
    for (int i = 1; i < busy_cycles; i++) begin
      tick();
      chk("done_early", o_done, 4'b0000);
    end
    i_tx_busy = 1'b0;
    tick();
    chk("done_pulse", o_done, exp_done);
    chk("data_stable", o_tx_data, exp_data);
    chk("err_quiet", o_err, 1'b0);
    tick();
    chk("done_clear", o_done, 4'b0000);
    chk("idle_busy", o_busy, 1'b0);
  endtask

  initial begin
    i_reset   = 1'b1;
    i_req     = '0;
    i_data    = 32'h3C965AA5;
    i_tx_busy = 1'b0;
    tick();
    tick();
    chk("rst_ack", o_ack, 4'b0000);
    chk("rst_done", o_done, 4'b0000);
    chk("rst_start", o_tx_start, 1'b0);
    chk("rst_data", o_tx_data, 8'h00);
    chk("rst_gid", o_grant_id, 3'd0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_err", o_err, 1'b0);
    i_reset = 1'b0;

    // single request, start held 4 cycles, busy 10 cycles
    i_req = 4'b0001;
    tick();
    chk("t1_ack", o_ack, 4'b0001);
    chk("t1_start", o_tx_start, 1'b1);
    chk("t1_data", o_tx_data, 8'hA5);
    chk("t1_gid", o_grant_id, 3'd0);
    i_req = 4'b0000;
    tick();
    chk("t1_ack_pulse", o_ack, 4'b0000);
    run_frame(3, 10, 4'b0001, 8'hA5);

    // simultaneous 0101 from reset
    do_reset();
    i_req = 4'b0101;
    tick();
    chk("t2_ack0", o_ack, 4'b0001);
    i_req = 4'b0100;
    run_frame(2, 3, 4'b0001, 8'hA5);
    tick();
    chk("t2_ack2", o_ack, 4'b0100);
    chk("t2_gid", o_grant_id, 3'd2);
    chk("t2_data", o_tx_data, 8'h96);
    i_req = 4'b0000;
    run_frame(1, 2, 4'b0100, 8'h96);

    // all four requesting for six frames
    do_reset();
    i_req = 4'b1111;
    for (int f = 0; f < 6; f++) begin
      tick();
      chk("t3_gid", o_grant_id, 3'(rr_exp[f]));
      chk("t3_ack", o_ack, 4'b0001 << rr_exp[f]);
      run_frame(1, 2, 4'b0001 << rr_exp[f], byte_of[rr_exp[f]]);
    end
    i_req = 4'b0000;

    // foreign frame holds off the grant
    i_tx_busy = 1'b1;
    i_req     = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_noack", o_ack, 4'b0000);
      chk("t4_idle", o_busy, 1'b0);
    end
    i_tx_busy = 1'b0;
    tick();
    chk("t4_ack", o_ack, 4'b0010);
    i_req = 4'b0000;
    run_frame(2, 2, 4'b0010, 8'h5A);

    // reset in SEND aborts without done
    i_req = 4'b0100;
    tick();
    chk("t5_ack", o_ack, 4'b0100);
    i_req     = 4'b0000;
    i_tx_busy = 1'b1;
    tick();
    chk("t5_send", o_tx_start, 1'b0);
    #3 i_reset = 1'b1;
    #1;
    chk("t5_rst_busy", o_busy, 1'b0);
    chk("t5_rst_done", o_done, 4'b0000);
    chk("t5_rst_gid", o_grant_id, 3'd0);
    chk("t5_rst_data", o_tx_data, 8'h00);
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    i_req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_wait_ack", o_ack, 4'b0000);
      chk("t5_wait_done", o_done, 4'b0000);
    end
    i_tx_busy = 1'b0;
    tick();
    chk("t5_ack0", o_ack, 4'b0001);
    i_req = 4'b0000;
    run_frame(1, 2, 4'b0001, 8'hA5);

`ifdef UART_TX_ARB_TIMEOUT_EN
    // watchdog: busy never rises
    i_req = 4'b0010;
    tick();
    chk("t6_ack", o_ack, 4'b0010);
    i_req = 4'b0000;
    for (int i = 2; i <= 20; i++) begin
      tick();
      chk("t6_start", o_tx_start, 1'b1);
      chk("t6_noerr", o_err, 1'b0);
    end
    tick();
    chk("t6_drop", o_tx_start, 1'b0);
    chk("t6_err", o_err, 1'b1);
    chk("t6_done", o_done, 4'b0010);
    tick();
    chk("t6_err_clr", o_err, 1'b0);
    chk("t6_idle", o_busy, 1'b0);
    i_req = 4'b0001;
    tick();
    chk("t6_next_ack", o_ack, 4'b0001);
    i_req = 4'b0000;
    run_frame(1, 2, 4'b0001, 8'hA5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
